interp_tap_accumulator: RTL and testbench

- Downstream stage of the per-tap MCM coefficient blocks in the interpolation filter.
- Takes the eight signed products for one output position, one per filter tap, already produced by the MCM multipliers, and reduces them in a pipelined adder tree.
- Applies the pass-dependent shift, rounding and clipping.
- Emits one filtered sample per accepted input, with valid/ready flow control on both sides.

---
 rtl/interp_tap_accumulator_if.sv | 23 ++
 rtl/interp_tap_accumulator.sv | 108 ++++++++++
 tb/tb_interp_tap_accumulator.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/interp_tap_accumulator_if.sv
// Stream bundle between the per-tap MCM products and the accumulator's sample output.
// slave is the accumulator side; master drives products and consumes samples.
interface interp_tap_accumulator_if #(
    parameter int PROD_W = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_mode;
    logic [8*PROD_W-1:0]   in_p;
    logic                  out_valid;
    logic                  out_ready;
    logic [15:0]           out_y;

    modport slave (
        input  in_valid, in_mode, in_p, out_ready,
        output in_ready, out_valid, out_y
    );

    modport master (
        output in_valid, in_mode, in_p, out_ready,
        input  in_ready, out_valid, out_y
    );
endinterface

// File: rtl/interp_tap_accumulator.sv
// Eight-tap adder tree with pass-dependent shift/round/clip; 3-cycle latency.
// Whole pipe freezes while the output is held (in_ready = !out_valid || out_ready).
module interp_tap_accumulator #(
    parameter int PROD_W    = 16,
    parameter int BIT_DEPTH = 8,
    parameter int SHIFT1    = 0,
    parameter int SHIFT2    = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    interp_tap_accumulator_if.slave  bus
);
    localparam int S1W = PROD_W + 1;
    localparam int S2W = PROD_W + 2;
    localparam int S3W = PROD_W + 3;
    // One guard bit above the full sum so the rounding add cannot wrap, and at
    // least wide enough to hold the 16-bit saturation bounds.
    localparam int EW  = (S3W + 1 > 18) ? S3W + 1 : 18;

    localparam logic signed [EW-1:0] RND  = EW'((1 << SHIFT2) >> 1);
    localparam logic signed [EW-1:0] SMAX = EW'(32767);
    localparam logic signed [EW-1:0] SMIN = EW'(-32768);
    localparam logic signed [EW-1:0] CMAX = EW'((1 << BIT_DEPTH) - 1);

    logic                adv;
    logic                s1_vld, s1_mode;
    logic [S1W-1:0]      s1_sum [4];
    logic                s2_vld, s2_mode;
    logic [S2W-1:0]      s2_sum [2];
    logic                out_vld;
    logic [15:0]         out_dat;

    logic [PROD_W-1:0]   tap    [8];
    logic [S1W-1:0]      s1_nxt [4];
    logic [S2W-1:0]      s2_nxt [2];
    logic [S3W-1:0]      s3_sum;
    logic signed [EW-1:0] s3_ext;
    logic signed [EW-1:0] r0;
    logic signed [EW-1:0] r1;
    logic [15:0]         y_nxt;

    assign adv           = !out_vld || bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.out_valid = out_vld;
    assign bus.out_y     = out_dat;

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            tap[i] = bus.in_p[i*PROD_W +: PROD_W];
        end
        for (int j = 0; j < 4; j++) begin
            s1_nxt[j] = {tap[2*j][PROD_W-1], tap[2*j]} + {tap[2*j+1][PROD_W-1], tap[2*j+1]};
        end
        for (int k = 0; k < 2; k++) begin
            s2_nxt[k] = {s1_sum[2*k][S1W-1], s1_sum[2*k]} + {s1_sum[2*k+1][S1W-1], s1_sum[2*k+1]};
        end
        s3_sum = {s2_sum[0][S2W-1], s2_sum[0]} + {s2_sum[1][S2W-1], s2_sum[1]};
        s3_ext = {{(EW-S3W){s3_sum[S3W-1]}}, s3_sum};
        r0     = s3_ext >>> SHIFT1;
        r1     = (s3_ext + RND) >>> SHIFT2;

        y_nxt = '0;
        if (s2_mode) begin
            if (r1[EW-1])
                y_nxt = '0;
            else if (r1 > CMAX)
                y_nxt = CMAX[15:0];
            else
                y_nxt = r1[15:0];
        end else begin
            if (r0 > SMAX)
                y_nxt = SMAX[15:0];
            else if (r0 < SMIN)
                y_nxt = SMIN[15:0];
            else
                y_nxt = r0[15:0];
        end
    end

    // Valid bits and the visible output register are the only reset state.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld  <= 1'b0;
            s2_vld  <= 1'b0;
            out_vld <= 1'b0;
            out_dat <= '0;
        end else if (adv) begin
            s1_vld  <= bus.in_valid;
            s2_vld  <= s1_vld;
            out_vld <= s2_vld;
            if (s2_vld)
                out_dat <= y_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            if (bus.in_valid) begin
                s1_mode <= bus.in_mode;
                s1_sum  <= s1_nxt;
            end
            if (s1_vld) begin
                s2_mode <= s1_mode;
                s2_sum  <= s2_nxt;
            end
        end
    end
endmodule

// File: tb/tb_interp_tap_accumulator.sv
// Scoreboarded bench for interp_tap_accumulator: directed vectors, stalls, bubbles, reset flush.
module tb_interp_tap_accumulator;
    logic clk;
    logic rst;

    interp_tap_accumulator_if #(.PROD_W(16)) ifc ();

    interp_tap_accumulator #(
        .PROD_W(16), .BIT_DEPTH(8), .SHIFT1(0), .SHIFT2(6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    int          n_chk = 0;
    int          n_err = 0;
    logic [15:0] sb [$];
    logic [15:0] exp_cur;
    logic        lat_chk;
    logic [2:0]  hist;
    logic        prev_stall;
    logic [15:0] prev_y;
    int          last_wait;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] pk(input int t0, input int t1, input int t2, input int t3,
                                        input int t4, input int t5, input int t6, input int t7);
        return {16'(t7), 16'(t6), 16'(t5), 16'(t4), 16'(t3), 16'(t2), 16'(t1), 16'(t0)};
    endfunction

    function automatic logic [15:0] model(input logic [127:0] p, input logic m);
        int s;
        int r;
        s = 0;
        for (int i = 0; i < 8; i++) s += int'($signed(p[i*16 +: 16]));
        if (m) begin
            r = (s + 32) >>> 6;
            if (r < 0)   r = 0;
            if (r > 255) r = 255;
        end else begin
            r = s;
            if (r > 32767)  r = 32767;
            if (r < -32768) r = -32768;
        end
        return r[15:0];
    endfunction

    // Transfers are judged at the falling edge: inputs move only just after rising edges.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            hist       = '0;
            prev_stall = 1'b0;
        end else begin
            chk("in_ready", {31'd0, ifc.in_ready}, {31'd0, (!ifc.out_valid || ifc.out_ready)});
            if (prev_stall) begin
                chk("stall_valid", {31'd0, ifc.out_valid}, 32'd1);
                chk("stall_y", {16'd0, ifc.out_y}, {16'd0, prev_y});
            end
            if (lat_chk)
                chk("latency", {31'd0, ifc.out_valid}, {31'd0, hist[2]});
            if (ifc.out_valid && ifc.out_ready) begin
                if (sb.size() == 0)
                    chk("unexpected_out", {31'd0, ifc.out_valid}, 32'd0);
                else
                    chk("out_y", {16'd0, ifc.out_y}, {16'd0, sb.pop_front()});
            end
            if (ifc.in_valid && ifc.in_ready)
                sb.push_back(exp_cur);
            hist       = {hist[1:0], ifc.in_valid && ifc.in_ready};
            prev_stall = ifc.out_valid && !ifc.out_ready;
            prev_y     = ifc.out_y;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [127:0] p, input logic m, input logic [15:0] e);
        int   g;
        logic ok;
        ifc.in_valid = 1'b1;
        ifc.in_p     = p;
        ifc.in_mode  = m;
        exp_cur      = e;
        g  = 0;
        ok = 1'b0;
        while (!ok && g < 100) begin
            @(negedge clk);
            ok = ifc.in_ready;
            @(posedge clk);
            #1;
            g++;
        end
        if (!ok) chk("send_timeout", {31'd0, ifc.in_ready}, 32'd1);
        last_wait    = g;
        ifc.in_valid = 1'b0;
    endtask

    initial begin
        logic [127:0] p;
        logic         v;
        logic         m;
        int           g;

        rst           = 1'b1;
        lat_chk       = 1'b0;
        exp_cur       = '0;
        hist          = '0;
        prev_stall    = 1'b0;
        prev_y        = '0;
        ifc.in_valid  = 1'b0;
        ifc.in_mode   = 1'b0;
        ifc.in_p      = '0;
        ifc.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_out_valid", {31'd0, ifc.out_valid}, 32'd0);
        chk("rst_out_y", {16'd0, ifc.out_y}, 32'd0);
        chk("rst_in_ready", {31'd0, ifc.in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Directed arithmetic, with the 3-cycle latency tracked throughout.
        lat_chk = 1'b1;
        send('0, 1'b1, 16'd0);
        idle(5);
        send(pk(-100, 400, -1000, 5800, 1700, -500, 200, -100), 1'b1, 16'd100);
        send(pk(-100, 400, -1000, 5800, 1700, -500, 200, -100), 1'b0, 16'd6400);
        send(pk(-500, 0, 0, 0, 0, 0, 0, 0), 1'b1, 16'd0);
        send(pk(20000, 0, 0, 0, 0, 0, 0, 0), 1'b1, 16'd255);
        send(pk(32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767), 1'b0, 16'h7fff);
        send(pk(-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768), 1'b0, 16'h8000);
        idle(6);

        // Back-to-back stream with a 3-cycle output stall.
        lat_chk = 1'b0;
        fork
            begin
                for (int k = 0; k < 10; k++)
                    send(pk(64 * k, 0, 0, 0, 0, 0, 0, 0), 1'b1, 16'(k));
            end
            begin
                repeat (5) @(posedge clk);
                #1 ifc.out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 ifc.out_ready = 1'b1;
            end
        join
        idle(8);

        // Bubbles: random in_valid, random data even when not valid.
        lat_chk = 1'b1;
        for (int c = 0; c < 30; c++) begin
            v = 1'($urandom_range(0, 1));
            m = 1'($urandom_range(0, 1));
            for (int i = 0; i < 8; i++)
                p[i*16 +: 16] = 16'(int'($urandom_range(0, 8000)) - 4000);
            ifc.in_valid = v;
            ifc.in_p     = p;
            ifc.in_mode  = m;
            exp_cur      = model(p, m);
            @(posedge clk);
            #1;
        end
        ifc.in_valid = 1'b0;
        idle(6);

        // Reset with three samples in flight; none of them may emerge.
        lat_chk = 1'b0;
        send(pk(6400, 0, 0, 0, 0, 0, 0, 0), 1'b1, 16'd100);
        send(pk(128, 0, 0, 0, 0, 0, 0, 0), 1'b1, 16'd2);
        send(pk(192, 0, 0, 0, 0, 0, 0, 0), 1'b1, 16'd3);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", {31'd0, ifc.out_valid}, 32'd0);
        chk("post_rst_ready", {31'd0, ifc.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        lat_chk = 1'b1;
        send(pk(640, 0, 0, 0, 0, 0, 0, 0), 1'b1, 16'd10);
        chk("post_rst_accept", last_wait, 32'd1);
        idle(6);

        g = 0;
        while (sb.size() != 0 && g < 50) begin
            @(posedge clk);
            g++;
        end
        chk("drain", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
